// File: rtl/serial_tx_if.sv
// Word handshake between a parallel source and the serial transmitter.
// The source drives D/valid; the transmitter answers with ready.
interface serial_tx_if #(
   parameter int N = 8
);
   logic [N-1:0] D;
   logic         valid;
   logic         ready;

   modport master (
      output D,
      output valid,
      input  ready
   );

   modport slave (
      input  D,
      input  valid,
      output ready
   );
endinterface

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start 0, N data bits LSB-first,
// stop 1, each bit held for CLKS_PER_BIT enabled clocks.
module serial_tx #(
   parameter int N            = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   serial_tx_if.slave  bus,
   output logic        tx,
   output logic        busy
);
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam int IW = $clog2(N) + 1;
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] I_LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [IW-1:0] r_idx, w_idx;
   logic [N-1:0]  r_shift, w_shift, w_shift_dn;
   logic          r_tx, w_tx;
   logic          r_busy, w_busy;
   logic          w_ready, w_bit_end;

   // ready is forced low while reset is held so no word slips in
   assign w_ready    = rst && en && (r_state == IDLE);
   assign w_bit_end  = (r_cnt == C_LAST);
   assign w_shift_dn = r_shift >> 1;
   assign bus.ready  = w_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_shift = r_shift;
      w_tx    = r_tx;
      w_busy  = r_busy;
      unique case (r_state)
         IDLE: begin
            if (bus.valid && w_ready) begin
               w_state = START;
               w_shift = bus.D;
               w_cnt   = '0;
               w_idx   = '0;
               w_tx    = 1'b0;
               w_busy  = 1'b1;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state = DATA;
               w_cnt   = '0;
               w_idx   = '0;
               w_tx    = r_shift[0];
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cnt   = '0;
               w_shift = w_shift_dn;
               w_idx   = r_idx + IW'(1);
               if (r_idx == I_LAST) begin
                  w_state = STOP;
                  w_tx    = 1'b1;
               end else begin
                  w_tx = w_shift_dn[0];
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state = IDLE;
               w_cnt   = '0;
               w_idx   = '0;
               w_tx    = 1'b1;
               w_busy  = 1'b0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state = IDLE;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
         end
      endcase
   end

   // en low freezes every register, so bit time counts enabled cycles only
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else if (en) begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_tx    <= w_tx;
         r_busy  <= w_busy;
      end
   end
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial framed transmitter: takes an N-bit word over a valid/ready handshake and shifts it out on one line.
- Frame is start bit (0), N data bits LSB-first, stop bit (1); each bit is held for CLKS_PER_BIT clocks.
- Drains words held in the team's N-bit enable-loaded register (the register's Q feeds D here).
- Pairs with a serial receiver elsewhere in the lab designs.

Parameters:
- N, 8, data word width in bits (N >= 1).
- CLKS_PER_BIT, 4, clock cycles per serial bit (>= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; low pauses the block, all state frozen.
- D  input  N  parallel word to transmit.
- valid  input  1  D is valid this cycle.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately without waiting for clk):
  - state = IDLE; tx = 1, busy = 0, bit counter = 0, cycle counter = 0, shift register = 0.
  - ready = 1 once rst returns high and en = 1.
- Reset mid-frame: frame aborted, tx returns to 1 at once, captured word discarded, no partial stop bit.
- Outputs tx and busy are registered. ready is combinational: ready = (state == IDLE) && en.
- Handshake:
  - Word accepted at the rising edge where valid && ready; D is captured into the shift register.
  - D and valid are ignored whenever ready = 0; no queuing.
- States:
  - IDLE: tx = 1, busy = 0. Accept moves to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles. Then shift right by 1 and increment the index. After index N-1 completes, move to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - tx reflects the new state on the cycle after the transition edge.
  - Accept edge to first start-bit cycle: 1 clock.
  - Full frame occupies exactly (N+2)*CLKS_PER_BIT cycles with busy = 1 (START through STOP inclusive).
- Back-to-back words:
  - The earliest next accept is the edge at the end of the first IDLE cycle after STOP.
  - So at least CLKS_PER_BIT+1 high cycles separate consecutive start bits.
- en = 0:
  - Cycle counter, bit index, shift register and state all hold; tx holds its current level; ready = 0.
  - Counting resumes where it stopped when en returns to 1, so bit duration counts only enabled cycles.
- Counter widths: cycle counter clog2(CLKS_PER_BIT)+1 bits; bit index clog2(N)+1 bits; no wrap artefacts at the maximum values.
- CLKS_PER_BIT = 1: one cycle per bit, same state sequence.
- valid held high continuously: words are taken one per frame, at each IDLE cycle.

Test Plan:
1. N=4, CLKS_PER_BIT=2. Reset low then high; valid=1, D=4'hA for one accept.
   -> From the next cycle, tx in 2-cycle units = 0,0,1,0,1,1 (12 cycles); busy high exactly 12 cycles; ready low throughout; then tx=1, ready=1.
2. Reset checks.
   -> While rst low: tx=1, busy=0, ready=0 at any time. During test 1, pull rst low mid-DATA (async, between edges): tx=1 and busy=0 immediately. After release, D=4'h3 transmits cleanly as 0,1,1,0,0,1.
3. en pause: during the DATA bit for D[1] of 4'hA, drop en for 5 cycles.
   -> tx holds 1 for those 5 cycles plus its 2 enabled cycles; ready stays 0; the remaining frame matches test 1; busy lasts 17 cycles.
4. valid held high with D=4'h6 then 4'h9 (D changed after the first accept).
   -> Two complete frames, 4'h6 then 4'h9. Gap between the stop bit end and the second start bit is exactly 1 idle cycle. D changes while busy have no effect.
5. Ignored request: assert valid with D=4'hF while busy, deassert before the frame ends.
   -> No extra frame; tx stays 1 after the stop bit.
6. N=8, CLKS_PER_BIT=1, D=8'h80.
   -> tx = 0, seven 0s, 1, 1 on consecutive cycles; busy for 10 cycles.
